uart_tx_param: RTL and testbench

//  Parametrised successor of the UART_TX top: serialises DATA_WIDTH-bit words into

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_param_baud_tick.sv | 33 +++
 rtl/uart_tx_param.sv | 158 +++++++++++++++
 tb/tb_uart_tx_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the parametrised UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2S = 3'd5
  } tx_state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;

endpackage

// File: rtl/uart_tx_param_baud_tick.sv
// Per-bit prescale counter: bit_tick marks the last clock of every bit period.
module uart_baud_tick #(
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic                   active,
  input  logic [PRESC_WIDTH-1:0] prescale,
  output logic                   bit_tick
);

  logic [PRESC_WIDTH-1:0] cnt;
  logic [PRESC_WIDTH-1:0] last_cnt;
  logic                   at_last;

  // A prescale of zero behaves as one clock per bit.
  assign last_cnt = (prescale == '0) ? '0 : prescale - PRESC_WIDTH'(1);
  assign at_last  = (cnt == last_cnt);
  assign bit_tick = active & at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (active) begin
      if (at_last) cnt <= '0;
      else         cnt <= cnt + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with holding register, internal baud divider and
// configuration latched per frame.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  output logic                   DATA_READY,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  output logic                   TX_OUT,
  output logic                   Busy,
  output logic                   FRAME_DONE
);

  tx_state_t state, state_next;

  logic                   hold_full;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   hold_par_en, hold_par_typ, hold_stop2;
  logic [PRESC_WIDTH-1:0] hold_presc;

  logic                   cur_par_en, cur_stop2;
  logic [PRESC_WIDTH-1:0] cur_presc;

  logic [DATA_WIDTH-1:0]  shift, shift_next;
  logic [3:0]             bit_cnt, bit_cnt_next;
  logic                   par_bit, par_next;
  logic                   tx_q, tx_next;

  logic accept, frame_start, frame_done, bit_tick, active;

  assign DATA_READY = ~hold_full;
  assign accept     = DATA_VALID & ~hold_full;
  assign active     = (state != IDLE);
  assign Busy       = active;
  assign FRAME_DONE = frame_done;
  assign TX_OUT     = tx_q;

  uart_baud_tick #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_baud (
    .clk     (CLK),
    .rst     (RST),
    .restart (frame_start),
    .active  (active),
    .prescale(cur_presc),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    frame_start  = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      IDLE: if (hold_full) begin
        state_next  = START;
        frame_start = 1'b1;
      end
      START: if (bit_tick) begin
        state_next   = DATA;
        bit_cnt_next = '0;
      end
      DATA: if (bit_tick) begin
        if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
          state_next = cur_par_en ? PARITY : STOP1;
        end else begin
          bit_cnt_next = bit_cnt + 4'd1;
          shift_next   = shift >> 1;
        end
      end
      PARITY: if (bit_tick) state_next = STOP1;
      STOP1, STOP2S: if (bit_tick) begin
        if (state == STOP1 && cur_stop2) begin
          state_next = STOP2S;
        end else begin
          // Final stop tick: chain straight into the next frame when one is waiting.
          frame_done = 1'b1;
          if (hold_full) begin
            state_next  = START;
            frame_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (frame_start) begin
      shift_next   = hold_data;
      bit_cnt_next = '0;
    end
  end

  assign par_next = frame_start ? (^hold_data ^ hold_par_typ) : par_bit;

  // Line level is registered from the next state so it changes with the state.
  always_comb begin
    tx_next = TX_IDLE_LVL;
    unique case (state_next)
      START:   tx_next = START_LVL;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = TX_IDLE_LVL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
      hold_stop2   <= 1'b0;
      hold_presc   <= '0;
      cur_par_en   <= 1'b0;
      cur_stop2    <= 1'b0;
      cur_presc    <= '0;
      shift        <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      tx_q         <= TX_IDLE_LVL;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      par_bit <= par_next;
      tx_q    <= tx_next;
      if (accept) begin
        hold_full    <= 1'b1;
        hold_data    <= P_DATA;
        hold_par_en  <= PAR_EN;
        hold_par_typ <= PAR_TYP;
        hold_stop2   <= STOP2;
        hold_presc   <= PRESCALE;
      end else if (frame_start) begin
        hold_full <= 1'b0;
      end
      if (frame_start) begin
        cur_par_en <= hold_par_en;
        cur_stop2  <= hold_stop2;
        cur_presc  <= hold_presc;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (8-bit and 7-bit instances).
module tb_uart_tx_param;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID, DATA_READY;
  logic       PAR_EN, PAR_TYP, STOP2;
  logic [5:0] PRESCALE;
  logic       TX_OUT, Busy, FRAME_DONE;

  logic [6:0] d7_data;
  logic       d7_valid, d7_ready, d7_par_en, d7_par_typ, d7_stop2;
  logic [5:0] d7_presc;
  logic       d7_tx, d7_busy, d7_done;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  uart_tx_param #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .PRESCALE(PRESCALE), .TX_OUT(TX_OUT), .Busy(Busy), .FRAME_DONE(FRAME_DONE)
  );

  uart_tx_param #(.DATA_WIDTH(7), .PRESC_WIDTH(6)) dut7 (
    .CLK(CLK), .RST(RST), .P_DATA(d7_data), .DATA_VALID(d7_valid),
    .DATA_READY(d7_ready), .PAR_EN(d7_par_en), .PAR_TYP(d7_par_typ), .STOP2(d7_stop2),
    .PRESCALE(d7_presc), .TX_OUT(d7_tx), .Busy(d7_busy), .FRAME_DONE(d7_done)
  );

  // Expected line level for bit slot idx of a frame.
  function automatic logic exp_bit(input logic [8:0] d, input int dw, input logic pe,
                                   input logic pt, input int idx);
    logic p;
    p = pt;
    for (int k = 0; k < dw; k++) p ^= d[k];
    if (idx == 0) return 1'b0;
    if (idx <= dw) return d[idx-1];
    if (pe && idx == dw + 1) return p;
    return 1'b1;
  endfunction

  // Present a word; returns at the negedge following the accepting edge.
  task automatic offer(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input logic [5:0] ps);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps;
    DATA_VALID = 1'b1;
    for (int n = 0; n < 200 && !DATA_READY; n++) @(negedge CLK);
    checks++;
    if (DATA_READY !== 1'b1) begin
      errors++;
      $display("FAIL offer_timeout: DATA_READY=%b required 1", DATA_READY);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks += 4;
    if (TX_OUT !== 1'b1)     begin errors++; $display("FAIL rst_tx: got %b required 1", TX_OUT); end
    if (Busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b required 0", Busy); end
    if (DATA_READY !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", DATA_READY); end
    if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", FRAME_DONE); end
    RST = 1'b0;
    offer(8'hFF, 1'b0, 1'b0, 1'b0, 6'd4);
    offer(8'h12, 1'b0, 1'b0, 1'b0, 6'd4);
    checks += 2;
    if (Busy !== 1'b1)       begin errors++; $display("FAIL midframe_busy: got %b required 1", Busy); end
    if (DATA_READY !== 1'b0) begin errors++; $display("FAIL midframe_ready: got %b required 0", DATA_READY); end
    RST = 1'b1;
    @(negedge CLK);
    checks += 3;
    if (TX_OUT !== 1'b1)     begin errors++; $display("FAIL abort_tx: got %b required 1", TX_OUT); end
    if (Busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b required 0", Busy); end
    if (DATA_READY !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", DATA_READY); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL no_resume[%0d]: tx=%b busy=%b required tx=1 busy=0", i, TX_OUT, Busy);
      end
    end
  endtask

  task automatic test_basic_frame;
    logic exp [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   done_cnt = 0;
    offer(8'hA5, 1'b0, 1'b0, 1'b0, 6'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      done_cnt += int'(FRAME_DONE);
      checks++;
      if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
        errors++;
        $display("FAIL a5_bit[%0d]: tx=%b busy=%b required tx=%b busy=1", i, TX_OUT, Busy, exp[i]);
      end
      if (i == 9) begin
        checks++;
        if (FRAME_DONE !== 1'b1) begin errors++; $display("FAIL a5_done_last: got %b required 1", FRAME_DONE); end
      end
    end
    @(negedge CLK);
    checks += 2;
    if (done_cnt != 1) begin errors++; $display("FAIL a5_done_count: got %0d required 1", done_cnt); end
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_after: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_parity;
    for (int t = 0; t < 2; t++) begin
      logic pt;
      int   busy_cycles = 0;
      pt = (t == 1);
      offer(8'h03, 1'b1, pt, 1'b0, 6'd4);
      for (int i = 0; i < 44; i++) begin
        @(negedge CLK);
        busy_cycles += int'(Busy);
        checks++;
        if (TX_OUT !== exp_bit({1'b0, 8'h03}, 8, 1'b1, pt, i / 4)) begin
          errors++;
          $display("FAIL par%0d_bit[%0d]: got %b required %b", t, i, TX_OUT,
                   exp_bit({1'b0, 8'h03}, 8, 1'b1, pt, i / 4));
        end
        if (i >= 36 && i < 40) begin
          checks++;
          if (TX_OUT !== pt) begin errors++; $display("FAIL par%0d_slot[%0d]: got %b required %b", t, i, TX_OUT, pt); end
        end
      end
      @(negedge CLK);
      checks++;
      if (busy_cycles != 44 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL par%0d_len: busy_cycles=%0d busy_after=%b required 44 and 0", t, busy_cycles, Busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0;
    offer(8'h55, 1'b0, 1'b0, 1'b1, 6'd2);
    fork
      begin
        for (int i = 0; i < 44; i++) begin
          logic e, r;
          @(negedge CLK);
          e = (i < 22) ? exp_bit({1'b0, 8'h55}, 8, 1'b0, 1'b0, i / 2)
                       : exp_bit({1'b0, 8'hF0}, 8, 1'b0, 1'b0, (i - 22) / 2);
          r = !(i >= 1 && i <= 21);
          done_cnt += int'(FRAME_DONE);
          checks++;
          if (TX_OUT !== e || Busy !== 1'b1 || DATA_READY !== r) begin
            errors++;
            $display("FAIL b2b[%0d]: tx=%b busy=%b ready=%b required tx=%b busy=1 ready=%b",
                     i, TX_OUT, Busy, DATA_READY, e, r);
          end
          if (i == 21 || i == 43) begin
            checks++;
            if (FRAME_DONE !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b required 1", i, FRAME_DONE); end
          end
        end
      end
      offer(8'hF0, 1'b0, 1'b0, 1'b1, 6'd2);
    join
    @(negedge CLK);
    checks += 2;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt); end
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  task automatic test_width7;
    int done_cnt = 0;
    @(negedge CLK);
    checks++;
    if (d7_ready !== 1'b1) begin errors++; $display("FAIL w7_ready: got %b required 1", d7_ready); end
    d7_data  = 7'h5A;
    d7_valid = 1'b1;
    @(negedge CLK);
    d7_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      done_cnt += int'(d7_done);
      checks++;
      if (d7_tx !== exp_bit({2'b0, 7'h5A}, 7, 1'b0, 1'b0, i) || d7_busy !== 1'b1) begin
        errors++;
        $display("FAIL w7_bit[%0d]: tx=%b busy=%b required tx=%b busy=1", i, d7_tx, d7_busy,
                 exp_bit({2'b0, 7'h5A}, 7, 1'b0, 1'b0, i));
      end
    end
    @(negedge CLK);
    checks += 2;
    if (done_cnt != 1) begin errors++; $display("FAIL w7_done_count: got %0d required 1", done_cnt); end
    if (d7_tx !== 1'b1 || d7_busy !== 1'b0) begin
      errors++;
      $display("FAIL w7_after: tx=%b busy=%b required tx=1 busy=0", d7_tx, d7_busy);
    end
  endtask

  task automatic test_config_latch;
    offer(8'hC3, 1'b0, 1'b0, 1'b0, 6'd3);
    fork
      begin
        for (int i = 0; i < 41; i++) begin
          logic e;
          @(negedge CLK);
          e = (i < 30) ? exp_bit({1'b0, 8'hC3}, 8, 1'b0, 1'b0, i / 3)
                       : exp_bit({1'b0, 8'h81}, 8, 1'b1, 1'b1, i - 30);
          checks++;
          if (TX_OUT !== e || Busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg[%0d]: tx=%b busy=%b required tx=%b busy=1", i, TX_OUT, Busy, e);
          end
        end
      end
      begin
        offer(8'h81, 1'b1, 1'b1, 1'b0, 6'd1);
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1; PRESCALE = 6'd5;
      end
    join
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_after: tx=%b busy=%b required tx=1 busy=0", TX_OUT, Busy);
    end
  endtask

  initial begin
    RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    STOP2 = 1'b0; PRESCALE = 6'd1;
    d7_data = '0; d7_valid = 1'b0; d7_par_en = 1'b0; d7_par_typ = 1'b0;
    d7_stop2 = 1'b0; d7_presc = 6'd0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_width7();
    test_config_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
